// File: rtl/types_pkg.sv
// Shared decode-stage types: immediate format selector and skid-buffer states.
package types_pkg;

    typedef enum logic [2:0] {
        Imm      = 3'd0,
        UpperImm = 3'd1,
        Store    = 3'd2,
        Branch   = 3'd3,
        Jump     = 3'd4,
        CsrImm   = 3'd5,
        Shamt    = 3'd6
    } instr_format;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned SIGN_BIT     = 31;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extractor/extender for one 32-bit instruction word.
module imm_extend_core
    import types_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    input  instr_format     ImmSrc,
    output logic [XLEN-1:0] ImmExt
);

    logic s;
    assign s = instr[SIGN_BIT];

    always_comb begin
        ImmExt = {{(XLEN-12){s}}, instr[31:20]};
        case (ImmSrc)
            Imm:      ImmExt = {{(XLEN-12){s}}, instr[31:20]};
            // Sign copies above bit 31 fall out of the shift for XLEN=64.
            UpperImm: ImmExt = {{(XLEN-20){s}}, instr[31:12]} << 12;
            Store:    ImmExt = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
            Branch:   ImmExt = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            Jump:     ImmExt = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            CsrImm:   ImmExt = {{(XLEN-5){1'b0}}, instr[19:15]};
            Shamt: begin
                if (XLEN == 64) ImmExt = {{(XLEN-6){1'b0}}, instr[25:20]};
                else            ImmExt = {{(XLEN-5){1'b0}}, instr[24:20]};
            end
            default:  ImmExt = {{(XLEN-12){s}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with valid/ready handshake, 2-entry skid buffer and flush.
module imm_extend_pipe
    import types_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  instr_format      ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic [TAG_W-1:0] out_tag
);

    buf_state         bufState;
    buf_state         nextState;
    logic [XLEN-1:0]  immExt;
    logic [XLEN-1:0]  skidImm;
    logic [TAG_W-1:0] skidTag;
    logic             accept;
    logic             loadMainIn;
    logic             loadMainSkid;
    logic             loadSkid;

    imm_extend_core #(.XLEN(XLEN)) extendCore (
        .instr  (instr),
        .ImmSrc (ImmSrc),
        .ImmExt (immExt)
    );

    // Handshake outputs decode only the state register, so ready never sees out_ready.
    assign out_valid = (bufState != BUF_EMPTY);
    assign in_ready  = (bufState != BUF_FULL);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) bufState <= BUF_EMPTY;
        else     bufState <= nextState;
    end

    always_comb begin
        nextState    = bufState;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            nextState = BUF_EMPTY;
        end else begin
            case (bufState)
                BUF_EMPTY: begin
                    if (accept) begin
                        loadMainIn = 1'b1;
                        nextState  = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && out_ready) begin
                        loadMainIn = 1'b1;
                    end else if (accept) begin
                        loadSkid  = 1'b1;
                        nextState = BUF_FULL;
                    end else if (out_ready) begin
                        nextState = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_ready) begin
                        loadMainSkid = 1'b1;
                        nextState    = BUF_ONE;
                    end
                end
                default: nextState = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ImmOp   <= '0;
            out_tag <= '0;
            skidImm <= '0;
            skidTag <= '0;
        end else begin
            if (loadMainIn) begin
                ImmOp   <= immExt;
                out_tag <= in_tag;
            end else if (loadMainSkid) begin
                ImmOp   <= skidImm;
                out_tag <= skidTag;
            end
            if (loadSkid) begin
                skidImm <= immExt;
                skidTag <= in_tag;
            end
        end
    end

endmodule
